// File: rtl/sha3_round_sequencer.sv
// sha3_round_sequencer
// Walks the Keccak-f[1600] round datapath through one permutation. Each round
// pulses round_sample, waits for round_good from the last stage, and then
// advances the iota round index. A per-round watchdog parks the FSM in a
// sticky error state if the datapath stops answering. Every output is a
// registered Moore output, decoded from the next state.

module sha3_round_sequencer #(
  parameter int ROUNDS   = 24,  // rounds per permutation, 1..32
  parameter int MAX_WAIT = 15   // WAIT cycles tolerated without round_good, 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       ready,
  output logic       busy,
  output logic       round_sample,
  input  logic       round_good,
  output logic [4:0] round_idx,
  output logic       feed_sel,
  output logic       done,
  output logic       error,
  input  logic       clear_err
);

  localparam int              CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
  localparam logic [4:0]       LAST_IDX = 5'(ROUNDS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]       r_state;
  logic [4:0]       r_round_idx;
  logic             r_feed_sel;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_ready;
  logic             r_busy;
  logic             r_sample;
  logic             r_done;
  logic             r_error;

  logic [2:0]       w_next_state;
  logic [4:0]       w_next_idx;
  logic             w_next_feed;
  logic [CNT_W-1:0] w_next_cnt;

  // Next-state, round index, feed select and watchdog counter.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case leaves it unassigned and no latch is inferred.
    w_next_state = r_state;
    w_next_idx   = r_round_idx;
    w_next_feed  = r_feed_sel;
    w_next_cnt   = r_wait_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_ISSUE;
          w_next_idx   = 5'd0;
          w_next_feed  = 1'b0;
        end
      end
      S_ISSUE: begin
        w_next_state = S_WAIT;
        w_next_cnt   = '0;
      end
      S_WAIT: begin
        // A response arriving on the last allowed cycle beats the timeout.
        if (round_good) begin
          if (r_round_idx == LAST_IDX) begin
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_ISSUE;
            w_next_idx   = r_round_idx + 5'd1;
            w_next_feed  = 1'b1;
          end
        end else begin
          if (r_wait_cnt != CNT_MAX) begin
            w_next_cnt = r_wait_cnt + 1'b1;
          end
          if (r_wait_cnt >= CNT_MAX - 1'b1) begin
            w_next_state = S_ERR;
          end
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
        w_next_idx   = 5'd0;
        w_next_feed  = 1'b0;
      end
      S_ERR: begin
        if (clear_err) begin
          w_next_state = S_IDLE;
          w_next_idx   = 5'd0;
          w_next_feed  = 1'b0;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_idx   = 5'd0;
        w_next_feed  = 1'b0;
        w_next_cnt   = '0;
      end
    endcase
  end

  // State plus Moore outputs decoded from the next state; async reset clears all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_round_idx <= 5'd0;
      r_feed_sel  <= 1'b0;
      r_wait_cnt  <= '0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_sample    <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from pre-edge values.
      r_state     <= w_next_state;
      r_round_idx <= w_next_idx;
      r_feed_sel  <= w_next_feed;
      r_wait_cnt  <= w_next_cnt;
      r_ready     <= (w_next_state == S_IDLE);
      r_busy      <= (w_next_state == S_ISSUE) || (w_next_state == S_WAIT) ||
                     (w_next_state == S_DONE);
      r_sample    <= (w_next_state == S_ISSUE);
      r_done      <= (w_next_state == S_DONE);
      r_error     <= (w_next_state == S_ERR);
    end
  end

  assign ready        = r_ready;
  assign busy         = r_busy;
  assign round_sample = r_sample;
  assign round_idx    = r_round_idx;
  assign feed_sel     = r_feed_sel;
  assign done         = r_done;
  assign error        = r_error;

endmodule

// File: tb/tb_sha3_round_sequencer.sv
// Bench for sha3_round_sequencer. Expected waveforms come from a per-permutation
// schedule: given each round's datapath latency, the cycle of every ISSUE,
// round_good and done follows by simple addition, and every output in every
// cycle is derived from that schedule.

module tb_sha3_round_sequencer;

  localparam int ROUNDS   = 24;
  localparam int MAX_WAIT = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       ready;
  logic       busy;
  logic       round_sample;
  logic       round_good;
  logic [4:0] round_idx;
  logic       feed_sel;
  logic       done;
  logic       error;
  logic       clear_err;

  int checks = 0;
  int errors = 0;
  int lat [ROUNDS];

  sha3_round_sequencer #(.ROUNDS(ROUNDS), .MAX_WAIT(MAX_WAIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ready        (ready),
    .busy         (busy),
    .round_sample (round_sample),
    .round_good   (round_good),
    .round_idx    (round_idx),
    .feed_sel     (feed_sel),
    .done         (done),
    .error        (error),
    .clear_err    (clear_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " ready"},  32'(ready), 1);
    chk({tag, " busy"},   32'(busy), 0);
    chk({tag, " sample"}, 32'(round_sample), 0);
    chk({tag, " done"},   32'(done), 0);
    chk({tag, " error"},  32'(error), 0);
    chk({tag, " idx"},    32'(round_idx), 0);
    chk({tag, " feed"},   32'(feed_sel), 0);
  endtask

  // One permutation using the latencies in lat[]. Called in an IDLE cycle,
  // which becomes cycle 0; returns in the cycle ready rises again. With hold
  // set, start stays high throughout, so the next request is already pending.
  task automatic run_perm(input string tag, input bit hold, input bit spur);
    int    issue_c [ROUNDS];
    int    good_c  [ROUNDS];
    int    done_c;
    int    nr;
    bit    exp_sample;
    bit    g;
    string ct;
    chk({tag, " ready@0"}, 32'(ready), 1);
    start      = 1'b1;
    round_good = 1'b0;
    issue_c[0] = 1;
    for (int r = 0; r < ROUNDS; r++) begin
      good_c[r] = issue_c[r] + lat[r];
      if (r + 1 < ROUNDS) issue_c[r+1] = good_c[r] + 1;
    end
    done_c = good_c[ROUNDS-1] + 1;
    for (int t = 1; t <= done_c + 1; t++) begin
      step();
      ct = $sformatf("%s c%0d", tag, t);
      nr = 0;
      exp_sample = 1'b0;
      for (int r = 0; r < ROUNDS; r++) begin
        if (good_c[r] < t) nr++;
        if (issue_c[r] == t) exp_sample = 1'b1;
      end
      if (nr > ROUNDS - 1) nr = ROUNDS - 1;
      if (t <= done_c) begin
        chk({ct, " busy"},   32'(busy), 1);
        chk({ct, " ready"},  32'(ready), 0);
        chk({ct, " sample"}, 32'(round_sample), 32'(exp_sample));
        chk({ct, " done"},   32'(done), 32'(t == done_c));
        chk({ct, " idx"},    32'(round_idx), nr);
        chk({ct, " feed"},   32'(feed_sel), 32'(nr > 0));
        chk({ct, " error"},  32'(error), 0);
      end else begin
        check_idle(ct);
      end
      g = 1'b0;
      for (int r = 0; r < ROUNDS; r++) if (good_c[r] == t) g = 1'b1;
      if (spur && (exp_sample || t == done_c)) g = 1'($urandom % 2);
      round_good = g;
      if (hold) start = 1'b1;
      else if (t <= done_c) start = 1'($urandom % 2);
      else start = 1'b0;
    end
    round_good = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; round_good = 1'b0; clear_err = 1'b0;

    // Reset takes effect with no clock edge, and holds after release.
    #1 rst = 1'b1;
    #1 check_idle("reset_async");
    step();
    step();
    rst = 1'b0;
    step();
    check_idle("reset_release");

    // 1-cycle datapath: done in cycle 49, ready in 50.
    for (int r = 0; r < ROUNDS; r++) lat[r] = 1;
    run_perm("perm_l1", 1'b0, 1'b0);

    // 3-cycle datapath with spurious round_good in ISSUE and DONE: done in 97.
    for (int r = 0; r < ROUNDS; r++) lat[r] = 3;
    run_perm("perm_l3", 1'b0, 1'b1);

    // Random latencies; round 0 answers on the last allowed WAIT cycle.
    for (int r = 0; r < ROUNDS; r++) lat[r] = int'($urandom_range(MAX_WAIT, 1));
    lat[0] = MAX_WAIT;
    run_perm("perm_rand", 1'b0, 1'b1);

    // start held high: the second permutation begins only once ready rises.
    for (int r = 0; r < ROUNDS; r++) lat[r] = int'($urandom_range(4, 1));
    run_perm("hold_a", 1'b1, 1'b0);
    for (int r = 0; r < ROUNDS; r++) lat[r] = int'($urandom_range(4, 1));
    run_perm("hold_b", 1'b0, 1'b0);

    // Timeout: no answer, WAIT entered in cycle 2, ERR in cycle 2+MAX_WAIT.
    chk("to ready@0", 32'(ready), 1);
    start = 1'b1;
    round_good = 1'b0;
    for (int t = 1; t < 2 + MAX_WAIT; t++) begin
      step();
      chk($sformatf("to c%0d busy", t),   32'(busy), 1);
      chk($sformatf("to c%0d sample", t), 32'(round_sample), 32'(t == 1));
      chk($sformatf("to c%0d error", t),  32'(error), 0);
      chk($sformatf("to c%0d idx", t),    32'(round_idx), 0);
      start = 1'($urandom % 2);
    end
    step();
    chk("to err error", 32'(error), 1);
    chk("to err ready", 32'(ready), 0);
    chk("to err busy",  32'(busy), 0);
    // start and round_good are both ignored in ERR.
    for (int k = 0; k < 4; k++) begin
      start = 1'b1;
      round_good = 1'($urandom % 2);
      step();
      chk($sformatf("err_hold%0d error", k),  32'(error), 1);
      chk($sformatf("err_hold%0d ready", k),  32'(ready), 0);
      chk($sformatf("err_hold%0d sample", k), 32'(round_sample), 0);
      chk($sformatf("err_hold%0d busy", k),   32'(busy), 0);
    end
    start = 1'b0;
    round_good = 1'b0;
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check_idle("clear_err");

    // Reset pulsed in round 10 of a 1-cycle-latency permutation.
    start = 1'b1;
    for (int t = 1; t <= 21; t++) begin
      step();
      start = 1'b0;
      round_good = 1'((t % 2) == 0 && t < 21);
    end
    chk("mid idx@round10", 32'(round_idx), 10);
    chk("mid sample@round10", 32'(round_sample), 1);
    round_good = 1'b0;
    step();
    #2 rst = 1'b1;
    #1 check_idle("mid_rst_async");
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("mid_rst hold%0d done", k), 32'(done), 0);
      chk($sformatf("mid_rst hold%0d ready", k), 32'(ready), 1);
    end
    rst = 1'b0;
    step();
    check_idle("mid_rst_release");

    // A fresh request after the abort runs a complete permutation.
    for (int r = 0; r < ROUNDS; r++) lat[r] = 1;
    run_perm("after_rst", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha3_round_sequencer.md
# sha3_round_sequencer

Sequences the Keccak-f[1600] round datapath (theta/rho/pi/chi/iota stage chain) through a full permutation. On each round it pulses the datapath `sample` input, waits for the last stage's `good`, and advances the round index that selects the iota constant. It also steers the state-input mux between the freshly absorbed state and the round-output feedback. It sits between the absorb/squeeze control and the round pipeline, and supervises the handshake with a per-round timeout.

## Interface
- `ROUNDS`, default 24: rounds per permutation; legal range 1..32.
- `MAX_WAIT`, default 15: maximum WAIT cycles allowed without `round_good` before the error state; legal range 1..255.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  permutation request; accepted only when `ready`=1.
- `ready`  out  1  high only in IDLE.
- `busy`  out  1  high in ISSUE, WAIT and DONE.
- `round_sample`  out  1  one-cycle pulse to the datapath `sample` input.
- `round_good`  in  1  `good` from the last round stage.
- `round_idx`  out  5  current round index; selects the iota constant.
- `feed_sel`  out  1  0 selects the absorbed state, 1 selects round feedback.
- `done`  out  1  one-cycle pulse when the final round completes.
- `error`  out  1  sticky timeout flag.
- `clear_err`  in  1  leave ERR and return to IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, DONE, ERR. All outputs are registered Moore outputs decoded from the next state.
- IDLE: `ready`=1. When `start`=1 the FSM goes to ISSUE with `round_idx`=0 and `feed_sel`=0.
- ISSUE: `round_sample`=1 for exactly this cycle. The FSM always goes to WAIT next.
- WAIT:
  - `round_good`=1 and `round_idx`==ROUNDS-1: go to DONE.
  - `round_good`=1 otherwise: increment `round_idx`, set `feed_sel`=1, go to ISSUE.
  - `round_good`=0: increment the wait counter. When the counter reaches MAX_WAIT, go to ERR.
  - The wait counter clears on every entry to WAIT.
- DONE: `done`=1 for one cycle, then IDLE. `round_idx` and `feed_sel` hold their values through DONE and reset to 0 on entry to IDLE.
- ERR: `error`=1, `ready`=0, `busy`=0. `clear_err` moves the FSM to IDLE and clears `error`. `start` is ignored while in ERR.
- `round_good` is ignored in IDLE, ISSUE, DONE and ERR. It causes no state change and no error.
- `start` is ignored in every state except IDLE. Requests are not queued.
- If `round_good` arrives on the same cycle the timeout would fire, `round_good` wins.
- `round_idx` never exceeds ROUNDS-1. It is 5 bits wide and zero-extended. The wait counter is $clog2(MAX_WAIT+1) bits wide and saturates.

## Timing
- Reset (asynchronous assert, synchronous release by the next clock edge):
  - State is IDLE.
  - `ready`=1.
  - `busy`, `round_sample`, `done`, `error` are 0.
  - `round_idx`=0, `feed_sel`=0, wait counter 0.
- Reset asserted mid-permutation: all outputs take their reset values immediately, without waiting for a clock. No `done` pulse is generated.
- Timeline with `start` sampled at edge of cycle 0 and a 1-cycle datapath (`good` = `sample` delayed one clock):
  - Round r: ISSUE in cycle 1+2r, WAIT in cycle 2+2r.
  - For ROUNDS=24: the last `round_good` is in cycle 48, `done`=1 in cycle 49, `ready`=1 in cycle 50.
- Datapath latency L≥1: each round takes L+1 cycles. Total from `start` to `done` is ROUNDS·(L+1)+1 cycles.
- Back-to-back permutations: `start` is accepted at the earliest in the cycle `ready` rises, i.e. two cycles after the final `round_good`.
- Timeout: entering WAIT in cycle t with no `round_good` gives ERR (`error`=1) in cycle t+MAX_WAIT.
- `clear_err` sampled in cycle c gives `ready`=1 in cycle c+1.

## Test plan
- Reset check: assert `rst` without any clock edge → `ready`=1, `busy`=0, `round_idx`=0, `error`=0 immediately. Check again after release.
- Full permutation, 1-cycle responder, ROUNDS=24:
  - `start` in cycle 0 → 24 `round_sample` pulses in cycles 1,3,…,47.
  - `round_idx` sequence is 0..23.
  - `feed_sel`=0 only for round 0.
  - `done` in cycle 49, `ready` in cycle 50.
- Stretched latency L=3: `start` in cycle 0 → `done` in cycle 97. Spurious `round_good` pulses injected in ISSUE cycles cause no extra round advance.
- Timeout, MAX_WAIT=15: responder never answers → ERR in cycle 17 with `error`=1. `start` is ignored while in ERR. `clear_err` → `ready`=1 the next cycle and `error`=0.
- Race: `round_good` on exactly the 15th WAIT cycle → no error, and the round advances.
- Abuse cases:
  - `start` held high throughout a permutation → a second permutation begins only after `ready` rises.
  - `rst` pulsed in round 10 → outputs reset asynchronously, no `done` pulse, and a fresh `start` runs a full 24-round permutation.
